// File: rtl/fetch_sequencer_pkg.sv
// Shared configuration for the fetch sequencer.
//   CFG_ADDRESS_LEN : default PC / address / instruction width.
//   INSTR_BYTES     : size of one instruction in bytes (PC step).
//   fetch_state_e   : sequencer state encoding (FETCH=0, HOLD=1, DISCARD=2).
package fetch_sequencer_pkg;

  localparam int CFG_ADDRESS_LEN = 32;
  localparam int INSTR_BYTES     = 4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction that arrives while the
// output entry is full and frozen.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   clear                  : drop the entry (redirect), beats load
//   load                   : capture {load_instr, load_next_pc}
//   unload                 : entry has moved to the output register
//   valid, instr, next_pc  : held entry
module fetch_skid_buffer
  import fetch_sequencer_pkg::*;
#(
  parameter int WIDTH = CFG_ADDRESS_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] load_instr,
  input  logic [WIDTH-1:0] load_next_pc,
  output logic             valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] next_pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the payload is qualified by valid, so it needs no reset; leaving it
  // out keeps the data path free of reset fan-out.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      instr   <= load_instr;
      next_pc <= load_next_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch controller. Owns the PC, issues req/ready
// fetches to instruction memory, presents fetched instructions to IF/ID via an
// output register backed by a one-entry skid buffer, and redirects on a taken
// branch while discarding any response still in flight for the old path.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   freeze            : downstream stall, output entry must be held
//   branch_taken      : redirect request from EXE
//   branch_address    : redirect target (low two bits ignored)
//   imem_req          : fetch request
//   imem_addr         : fetch address, stable until imem_ready
//   imem_ready        : one-cycle response strobe
//   imem_rdata        : fetched instruction
//   out_valid         : instruction_out / next_pc hold a valid entry
//   instruction_out   : fetched instruction
//   next_pc           : fetch address of instruction_out + 4
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                     ADDRESS_LEN = CFG_ADDRESS_LEN,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_address,
  output logic                   imem_req,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [ADDRESS_LEN-1:0] imem_rdata,
  output logic                   out_valid,
  output logic [ADDRESS_LEN-1:0] instruction_out,
  output logic [ADDRESS_LEN-1:0] next_pc
);

  localparam logic [ADDRESS_LEN-1:0] STEP       = ADDRESS_LEN'(INSTR_BYTES);
  localparam logic [ADDRESS_LEN-1:0] ALIGN_MASK = ~ADDRESS_LEN'(INSTR_BYTES - 1);

  fetch_state_e           state_q, state_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [ADDRESS_LEN-1:0] req_addr_q, req_addr_d;
  logic                   out_valid_q, out_valid_d;
  logic [ADDRESS_LEN-1:0] out_instr_q, out_instr_d;
  logic [ADDRESS_LEN-1:0] out_next_pc_q, out_next_pc_d;

  logic                   skid_load, skid_unload, skid_clear;
  logic                   skid_valid;
  logic [ADDRESS_LEN-1:0] skid_instr, skid_next_pc;

  logic [ADDRESS_LEN-1:0] target;
  logic [ADDRESS_LEN-1:0] req_addr_inc;
  logic                   consume;

  assign target       = branch_address & ALIGN_MASK;
  assign req_addr_inc = req_addr_q + STEP;  // wraps modulo 2^ADDRESS_LEN
  assign consume      = out_valid_q && !freeze;

  fetch_skid_buffer #(
    .WIDTH (ADDRESS_LEN)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .clear        (skid_clear),
    .load         (skid_load),
    .unload       (skid_unload),
    .load_instr   (imem_rdata),
    .load_next_pc (req_addr_inc),
    .valid        (skid_valid),
    .instr        (skid_instr),
    .next_pc      (skid_next_pc)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the branches leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    out_valid_d   = out_valid_q && !consume;
    out_instr_d   = out_instr_q;
    out_next_pc_d = out_next_pc_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_clear    = 1'b0;

    if (branch_taken) begin
      // Redirect wins over freeze: the old path's entries are dead.
      pc_d        = target;
      out_valid_d = 1'b0;
      skid_clear  = 1'b1;
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            req_addr_d = target;
          end else begin
            // Request still outstanding; its address must stay put until
            // the memory answers, so remember the target in pc only.
            state_d = DISCARD;
          end
        end
        HOLD: begin
          req_addr_d = target;
          state_d    = FETCH;
        end
        DISCARD: ;
        default: begin
          req_addr_d = target;
          state_d    = FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d       = req_addr_inc;
            req_addr_d = req_addr_inc;
            if (!out_valid_q || !freeze) begin
              out_valid_d   = 1'b1;
              out_instr_d   = imem_rdata;
              out_next_pc_d = req_addr_inc;
            end else begin
              // Output full and frozen: park the response and stop issuing.
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!freeze) begin
            // Output is consumed at this edge; refill it from the skid.
            if (skid_valid) begin
              skid_unload   = 1'b1;
              out_valid_d   = 1'b1;
              out_instr_d   = skid_instr;
              out_next_pc_d = skid_next_pc;
            end
            state_d = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ready) begin
            // Stale response dropped; start fetching the redirect target.
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        default: begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_next_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_next_pc_q <= out_next_pc_d;
    end
  end

  // Outputs come from registers; rst forces reset values in the same cycle.
  // imem_addr depends only on req_addr_q and rst, never on ready or freeze.
  assign imem_req        = !rst && (state_q == FETCH || state_q == DISCARD);
  assign imem_addr       = rst ? RESET_PC : req_addr_q;
  assign out_valid       = !rst && out_valid_q;
  assign instruction_out = rst ? '0 : out_instr_q;
  assign next_pc         = rst ? '0 : out_next_pc_q;

endmodule
